// File: rtl/compute_cluster_chunk_loader.sv
// Double-buffered IFM chunk loader: sequences the write beats into two ping-pong buffers
// and tracks per-buffer ready flags against compute-side release.
module compute_cluster_chunk_loader #(
  parameter int unsigned WR_DAT_CYC_NUM = 4,
  parameter int unsigned SRAM_IFM_NUM   = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [$clog2(SRAM_IFM_NUM):0]       chunk_num_i,
  input  logic                                chunk_consumed_i,
  output logic                                ifm_chunk_wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]   ifm_chunk_wr_count_o,
  output logic                                ifm_chunk_wr_sel_o,
  output logic                                ifm_chunk_rd_sel_o,
  output logic [$clog2(SRAM_IFM_NUM)-1:0]     ifm_sram_rd_count_o,
  output logic [1:0]                          ifm_chunk_rdy_o,
  output logic                                run_valid_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int unsigned CNT_W  = $clog2(SRAM_IFM_NUM) + 1;
  localparam int unsigned BEAT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int unsigned SRAM_W = $clog2(SRAM_IFM_NUM);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WR_DAT_CYC_NUM - 1);
  localparam logic [SRAM_W-1:0] LAST_SRAM = SRAM_W'(SRAM_IFM_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUF,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_wr_valid;
  logic [BEAT_W-1:0]   r_wr_count;
  logic                r_wr_sel;
  logic                r_rd_sel;
  logic [SRAM_W-1:0]   r_sram_cnt;
  logic [1:0]          r_rdy;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_loaded_cnt;
  logic [CNT_W-1:0]    r_consumed_cnt;
  logic [CNT_W-1:0]    r_total;

  logic                w_run_valid;
  logic                w_cons_fire;
  logic                w_last_beat;
  logic [1:0]          w_rdy_set;
  logic [1:0]          w_rdy_clr;
  logic                w_next_free;
  logic                w_job_end;
  logic [CNT_W-1:0]    w_loaded_inc;
  logic [CNT_W-1:0]    w_consumed_inc;

  // A release only counts when the selected buffer actually holds a ready chunk.
  assign w_run_valid    = r_rdy[r_rd_sel];
  assign w_cons_fire    = chunk_consumed_i && w_run_valid && (r_state != S_IDLE);
  assign w_last_beat    = (r_state == S_LOAD) && (r_wr_count == LAST_BEAT);
  assign w_rdy_set      = w_last_beat ? (2'b01 << r_wr_sel) : 2'b00;
  assign w_rdy_clr      = w_cons_fire ? (2'b01 << r_rd_sel) : 2'b00;
  assign w_next_free    = !r_rdy[~r_wr_sel] || w_rdy_clr[~r_wr_sel];
  assign w_loaded_inc   = r_loaded_cnt + CNT_W'(1);
  assign w_consumed_inc = r_consumed_cnt + CNT_W'(1);
  assign w_job_end      = (r_state == S_DRAIN) &&
                          ((w_cons_fire && (w_consumed_inc == r_total)) ||
                           (r_consumed_cnt == r_total));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_wr_valid     <= 1'b0;
      r_wr_count     <= '0;
      r_wr_sel       <= 1'b0;
      r_rd_sel       <= 1'b0;
      r_sram_cnt     <= '0;
      r_rdy          <= 2'b00;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_loaded_cnt   <= '0;
      r_consumed_cnt <= '0;
      r_total        <= '0;
    end else begin
      r_done <= 1'b0;
      r_rdy  <= (r_rdy | w_rdy_set) & ~w_rdy_clr;
      if (w_cons_fire) begin
        r_rd_sel       <= ~r_rd_sel;
        r_consumed_cnt <= w_consumed_inc;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (chunk_num_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_total        <= chunk_num_i;
              r_loaded_cnt   <= '0;
              r_consumed_cnt <= '0;
              r_wr_sel       <= 1'b0;
              r_rd_sel       <= 1'b0;
              r_rdy          <= 2'b00;
              r_sram_cnt     <= '0;
              r_wr_valid     <= 1'b1;
              r_wr_count     <= '0;
              r_busy         <= 1'b1;
              r_state        <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (w_last_beat) begin
            r_loaded_cnt <= w_loaded_inc;
            r_wr_sel     <= ~r_wr_sel;
            r_sram_cnt   <= (r_sram_cnt == LAST_SRAM) ? '0 : r_sram_cnt + SRAM_W'(1);
            r_wr_count   <= '0;
            if (w_loaded_inc == r_total) begin
              r_wr_valid <= 1'b0;
              r_state    <= S_DRAIN;
            end else if (w_next_free) begin
              r_wr_valid <= 1'b1;
            end else begin
              r_wr_valid <= 1'b0;
              r_state    <= S_WAIT_BUF;
            end
          end else begin
            r_wr_count <= r_wr_count + BEAT_W'(1);
          end
        end

        S_WAIT_BUF: begin
          if (!r_rdy[r_wr_sel]) begin
            r_wr_valid <= 1'b1;
            r_wr_count <= '0;
            r_state    <= S_LOAD;
          end
        end

        S_DRAIN: begin
          if (w_job_end) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifm_chunk_wr_valid_o = r_wr_valid;
  assign ifm_chunk_wr_count_o = r_wr_count;
  assign ifm_chunk_wr_sel_o   = r_wr_sel;
  assign ifm_chunk_rd_sel_o   = r_rd_sel;
  assign ifm_sram_rd_count_o  = r_sram_cnt;
  assign ifm_chunk_rdy_o      = r_rdy;
  assign run_valid_o          = w_run_valid;
  assign busy_o               = r_busy;
  assign done_o               = r_done;

endmodule

// File: doc/compute_cluster_chunk_loader.md
Name: compute_cluster_chunk_loader

Overview:
- Sequencing stage directly upstream of the compute-cluster/memory wrapper.
- Drives the IFM chunk write strobes, write-beat counter, SRAM chunk index, ping-pong buffer selects and per-buffer ready flags that the cluster and the IFM memory consume.
- Implements a two-entry double-buffer handshake. Chunk N+1 loads while chunk N is being computed, and loading stalls until a buffer is released by the compute side.

Parameters:
- WR_DAT_CYC_NUM, 4, write beats per chunk (must be ≥2).
- SRAM_IFM_NUM, 8, maximum chunks per job; width of the chunk index = $clog2(SRAM_IFM_NUM).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle job start pulse.
- chunk_num_i  in  $clog2(SRAM_IFM_NUM)+1  number of chunks in the job; sampled with start_i.
- chunk_consumed_i  in  1  compute side has finished the buffer selected by ifm_chunk_rd_sel_o.
- ifm_chunk_wr_valid_o  out  1  write beat valid.
- ifm_chunk_wr_count_o  out  $clog2(WR_DAT_CYC_NUM)  beat index within the chunk.
- ifm_chunk_wr_sel_o  out  1  buffer being written.
- ifm_chunk_rd_sel_o  out  1  buffer the compute side reads.
- ifm_sram_rd_count_o  out  $clog2(SRAM_IFM_NUM)  chunk index read from SRAM.
- ifm_chunk_rdy_o  out  2  per-buffer ready flags.
- run_valid_o  out  1  = ifm_chunk_rdy_o[ifm_chunk_rd_sel_o].
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse when the last chunk is consumed.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. All outputs are 0: wr_valid, wr_count, wr_sel, rd_sel, sram_rd_count, rdy = 2'b00, run_valid, busy, done.
- Internal registers:
  - loaded_cnt: chunks fully written.
  - consumed_cnt: chunks released.
  - total: latched chunk_num_i.
- States: IDLE, LOAD, WAIT_BUF, DRAIN.
- IDLE:
  - start_i=1 with chunk_num_i=0: done_o pulses the next cycle, state stays IDLE, busy stays 0.
  - start_i=1 with chunk_num_i>0: latch total, clear the counters, set wr_sel=0, rd_sel=0, rdy=0, sram_rd_count=0, then go to LOAD. busy_o=1 from the next cycle.
- start_i outside IDLE is ignored.
- LOAD:
  - wr_valid_o=1 every cycle; wr_count runs 0..WR_DAT_CYC_NUM-1 on consecutive cycles.
  - First beat is on the cycle after entry; with start at cycle 0, beats occur at cycles 1..W.
  - On the cycle after the last beat: rdy[wr_sel] sets, loaded_cnt increments, wr_sel toggles, sram_rd_count increments (wraps to 0 after SRAM_IFM_NUM-1).
  - Exit from the last-beat cycle:
    - loaded_cnt+1 == total → DRAIN.
    - Else, if the next buffer (!wr_sel) is free (its rdy is clear, or it is being consumed that same cycle) → LOAD, back-to-back with no bubble.
    - Else → WAIT_BUF.
- WAIT_BUF: wr_valid=0. Go to LOAD when rdy[wr_sel] is clear (the buffer was released).
- Consume handshake, in any non-IDLE state:
  - chunk_consumed_i with rdy[rd_sel]=1 clears rdy[rd_sel], toggles rd_sel and increments consumed_cnt on the next edge.
  - chunk_consumed_i with run_valid_o=0 is ignored (no state change).
- Simultaneous set and clear:
  - Set of one rdy bit plus clear of the other in the same cycle: both take effect.
  - Set and clear of the same bit cannot occur, because loading never targets a ready buffer.
- DRAIN: no writes. When consumed_cnt reaches total: done_o pulses one cycle, busy→0, go to IDLE. rdy is all 0 at this point.
- Outputs are registered, except run_valid_o, which is the combinational select of registered values.
- Invariant: at most 2 chunks are ready-or-loading ahead of consumption; a write never targets a buffer with rdy=1.
- Reset mid-job: immediate return to the reset values; no done pulse.

Test Plan:
- Reset then start, chunk_num=1, W=4, no consume:
  - wr_valid at cycles 1-4 with count 0,1,2,3, sel=0, sram_rd_count=0.
  - rdy=2'b01 and run_valid=1 at cycle 5; stays in DRAIN.
  - consume at cycle 7 → rdy=0 at cycle 8, done pulse, busy=0.
- chunk_num=3, no consume:
  - chunk0 beats at cycles 1-4 (sel 0); chunk1 beats at 5-8 (sel 1, sram 1); rdy=2'b11 at cycle 9; WAIT_BUF, wr_valid=0.
  - consume → rd_sel=1, rdy=2'b10, then chunk2 loads into buf0 with sram_rd_count=2.
- Consume in the same cycle as chunk1's last beat, while buf0 is ready: chunk2 starts on the next cycle with no bubble; rdy goes 01→10.
- chunk_consumed_i while run_valid=0: no change in rd_sel, rdy or counters.
- start with chunk_num=0: done pulses 1 cycle later; wr_valid is never asserted. A start_i during LOAD is ignored (total unchanged).
- rst_i asserted mid-LOAD at beat 2: all outputs are 0 asynchronously. After release, a new start runs a clean job from sram_rd_count=0.
